// File: rtl/alarm_clock_pkg.sv
// Shared types, limits and BCD time helpers for the multi-alarm clock.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  // Checks that a keypad HH:MM entry is a legal 24-hour time.
  function automatic logic valid_hhmm(hhmm_t t);
    int unsigned hr;
    int unsigned mn;
    hr = 32'(t.h1) * 10 + 32'(t.h0);
    mn = 32'(t.m1) * 10 + 32'(t.m0);
    return (hr <= MAX_HOUR) && (t.h0 <= 4'd9) && (mn <= MAX_MIN) && (t.m0 <= 4'd9);
  endfunction

  // Adds a minute offset to an HH:MM value, wrapping at midnight.
  function automatic hhmm_t bcd_add_minutes(hhmm_t t, int unsigned mins);
    int unsigned tot;
    int unsigned hr;
    int unsigned mn;
    hhmm_t       r;
    tot  = (32'(t.h1) * 10 + 32'(t.h0)) * (MAX_MIN + 1) + 32'(t.m1) * 10 + 32'(t.m0) + mins;
    tot  = tot % ((MAX_HOUR + 1) * (MAX_MIN + 1));
    hr   = tot / (MAX_MIN + 1);
    mn   = tot % (MAX_MIN + 1);
    r.h1 = 2'(hr / 10);
    r.h0 = 4'(hr % 10);
    r.m1 = 4'(mn / 10);
    r.m0 = 4'(mn % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Seconds divider plus 24-hour HH:MM:SS BCD counter with synchronous load.
module bcd_time_counter
  import alarm_clock_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ld,
  input  hhmm_t      i_ld_val,
  output hhmm_t      o_hhmm,
  output logic [3:0] o_s1,
  output logic [3:0] o_s0,
  output logic       o_tick,
  output logic       o_sec_wrap
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div;
  hhmm_t         r_hhmm;
  logic [3:0]    r_s1;
  logic [3:0]    r_s0;
  logic          w_tick;

  assign w_tick     = (r_div == DW'(CLK_DIV - 1));
  assign o_tick     = w_tick;
  // A tick leaving :59 means the seconds are about to read :00.
  assign o_sec_wrap = w_tick && (r_s1 == 4'd5) && (r_s0 == 4'd9);
  assign o_hhmm     = r_hhmm;
  assign o_s1       = r_s1;
  assign o_s0       = r_s0;

  // Divider and cascaded BCD digits; a load wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div  <= '0;
      r_hhmm <= '0;
      r_s1   <= '0;
      r_s0   <= '0;
    end else if (i_ld) begin
      r_div  <= '0;
      r_hhmm <= i_ld_val;
      r_s1   <= '0;
      r_s0   <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      if (r_s0 != 4'd9) r_s0 <= r_s0 + 4'd1;
      else begin
        r_s0 <= '0;
        if (r_s1 != 4'd5) r_s1 <= r_s1 + 4'd1;
        else begin
          r_s1 <= '0;
          if (r_hhmm.m0 != 4'd9) r_hhmm.m0 <= r_hhmm.m0 + 4'd1;
          else begin
            r_hhmm.m0 <= '0;
            if (r_hhmm.m1 != 4'd5) r_hhmm.m1 <= r_hhmm.m1 + 4'd1;
            else begin
              r_hhmm.m1 <= '0;
              if (r_hhmm.h1 == 2'd2 && r_hhmm.h0 == 4'd3) begin
                r_hhmm.h1 <= '0;
                r_hhmm.h0 <= '0;
              end else if (r_hhmm.h0 == 4'd9) begin
                r_hhmm.h0 <= '0;
                r_hhmm.h1 <= r_hhmm.h1 + 2'd1;
              end else begin
                r_hhmm.h0 <= r_hhmm.h0 + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

endmodule

// File: rtl/alarm_clock_multi.sv
// Multi-slot alarm clock: alarm slots, ring/snooze FSM and 12/24h display.
//   state      | meaning
//   ST_IDLE    | quiet, waiting for an enabled slot to match
//   ST_RINGING | Alarm high, ring counter counting seconds
//   ST_SNOOZED | quiet, waiting for the snooze target or a new match
module alarm_clock_multi
  import alarm_clock_pkg::*;
#(
  parameter  int CLK_DIV      = 10,
  parameter  int N_ALARMS     = 4,
  parameter  int SNOOZE_MIN   = 5,
  parameter  int RING_MAX_SEC = 60,
  localparam int SELW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [SELW-1:0]     alarm_sel,
  input  logic [N_ALARMS-1:0] AL_EN,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  input  logic                mode_12h,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0,
  output logic                PM,
  output logic                Alarm,
  output logic [SELW-1:0]     alarm_src,
  output logic                snoozed,
  output logic                tick_1s
);

  hhmm_t           w_in;
  hhmm_t           w_now;
  logic [3:0]      w_s1;
  logic [3:0]      w_s0;
  logic            w_tick;
  logic            w_sec_wrap;
  logic            w_ld_time_ok;
  logic            w_ld_alarm_ok;
  logic [31:0]     w_sel_ext;
  logic            w_match_any;
  logic [SELW-1:0] w_match_idx;
  logic [4:0]      w_hr;
  logic [4:0]      w_disp;

  hhmm_t           r_slot [N_ALARMS];
  logic            r_eval;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [SELW-1:0] r_src;
  logic [SELW-1:0] w_src_nxt;
  logic [7:0]      r_ring;
  logic [7:0]      w_ring_nxt;
  hhmm_t           r_target;
  hhmm_t           w_target_nxt;

  assign w_in          = {H_in1, H_in0, M_in1, M_in0};
  assign w_sel_ext     = 32'(alarm_sel);
  assign w_ld_time_ok  = LD_time && valid_hhmm(w_in);
  assign w_ld_alarm_ok = LD_alarm && valid_hhmm(w_in) && (w_sel_ext < 32'(N_ALARMS));

  bcd_time_counter #(.CLK_DIV(CLK_DIV)) u_time (
    .clk        (clk),
    .reset      (reset),
    .i_ld       (w_ld_time_ok),
    .i_ld_val   (w_in),
    .o_hhmm     (w_now),
    .o_s1       (w_s1),
    .o_s0       (w_s0),
    .o_tick     (w_tick),
    .o_sec_wrap (w_sec_wrap)
  );

  // Alarm slot storage, written only by a legal load to an existing slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_ALARMS; i++) r_slot[i] <= '0;
    end else if (w_ld_alarm_ok) begin
      r_slot[alarm_sel] <= w_in;
    end
  end

  // Flags the cycle in which the freshly updated time is compared to the slots.
  always_ff @(posedge clk) begin
    if (!reset) r_eval <= 1'b0;
    else        r_eval <= w_ld_time_ok || w_sec_wrap;
  end

  // Priority search over enabled slots; the lowest index wins.
  always_comb begin
    w_match_any = 1'b0;
    w_match_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (AL_EN[i] && (r_slot[i] == w_now)) begin
        w_match_any = 1'b1;
        w_match_idx = SELW'(i);
      end
    end
  end

  // FSM state, source slot, ring counter and snooze target registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_src    <= '0;
      r_ring   <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_src    <= w_src_nxt;
      r_ring   <= w_ring_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Next-state logic; STOP beats SNOOZE, which beats the ring timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_ring_nxt   = r_ring;
    w_target_nxt = r_target;
    case (r_state)
      ST_IDLE: begin
        if (r_eval && w_match_any) begin
          w_state_nxt = ST_RINGING;
          w_src_nxt   = w_match_idx;
          w_ring_nxt  = '0;
        end
      end
      ST_RINGING: begin
        if (STOP_al) begin
          w_state_nxt = ST_IDLE;
        end else if (SNOOZE) begin
          w_state_nxt  = ST_SNOOZED;
          w_target_nxt = bcd_add_minutes(w_now, 32'(SNOOZE_MIN));
        end else if (r_ring >= 8'(RING_MAX_SEC)) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_ring_nxt = r_ring + 8'd1;
        end
      end
      ST_SNOOZED: begin
        if (STOP_al) begin
          w_state_nxt = ST_IDLE;
        end else if ((w_now == r_target) && (w_s1 == 4'd0) && (w_s0 == 4'd0)) begin
          w_state_nxt = ST_RINGING;
          w_ring_nxt  = '0;
        end else if (r_eval && w_match_any) begin
          w_state_nxt = ST_RINGING;
          w_src_nxt   = w_match_idx;
          w_ring_nxt  = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign Alarm     = (r_state == ST_RINGING);
  assign snoozed   = (r_state == ST_SNOOZED);
  assign alarm_src = r_src;
  assign tick_1s   = w_tick;
  assign M_out1    = w_now.m1;
  assign M_out0    = w_now.m0;
  assign S_out1    = w_s1;
  assign S_out0    = w_s0;

  // Hour display: PM from the 24h hour, optional 12h remap, back to BCD.
  always_comb begin
    w_hr   = 5'(32'(w_now.h1) * 10 + 32'(w_now.h0));
    PM     = (w_hr >= 5'd12);
    w_disp = w_hr;
    if (mode_12h) begin
      if (w_hr == 5'd0)      w_disp = 5'd12;
      else if (w_hr > 5'd12) w_disp = w_hr - 5'd12;
    end
    if (w_disp >= 5'd20) begin
      H_out1 = 2'd2;
      H_out0 = 4'(w_disp - 5'd20);
    end else if (w_disp >= 5'd10) begin
      H_out1 = 2'd1;
      H_out0 = 4'(w_disp - 5'd10);
    end else begin
      H_out1 = 2'd0;
      H_out0 = 4'(w_disp);
    end
  end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Bench for alarm_clock_multi: directed scenarios plus random traffic,
// checked every cycle against a seconds-of-day reference model.
module tb_alarm_clock_multi;

  localparam int CLK_DIV = 4;
  localparam int N       = 4;
  localparam int SNZ     = 5;
  localparam int RMAX    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       LD_time, LD_alarm;
  logic [1:0] alarm_sel;
  logic [3:0] AL_EN;
  logic       STOP_al, SNOOZE, mode_12h;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic       PM, Alarm, snoozed, tick_1s;
  logic [1:0] alarm_src;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time as seconds of day, slots as minutes of day.
  int m_div, m_sec, m_src, m_rcnt, m_tgt, m_st;
  int m_slot[N];
  bit m_eval;

  alarm_clock_multi #(
    .CLK_DIV(CLK_DIV), .N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_MAX_SEC(RMAX)
  ) dut (
    .clk(clk), .reset(reset), .LD_time(LD_time), .LD_alarm(LD_alarm),
    .alarm_sel(alarm_sel), .AL_EN(AL_EN), .STOP_al(STOP_al), .SNOOZE(SNOOZE),
    .mode_12h(mode_12h), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .PM(PM), .Alarm(Alarm),
    .alarm_src(alarm_src), .snoozed(snoozed), .tick_1s(tick_1s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int  hr_in, mn_in, cur_min, hit;
    bit  ok, tick;
    if (!reset) begin
      m_div = 0; m_sec = 0; m_src = 0; m_rcnt = 0; m_tgt = 0; m_st = 0; m_eval = 0;
      for (int i = 0; i < N; i++) m_slot[i] = 0;
      return;
    end
    tick    = (m_div == CLK_DIV - 1);
    hr_in   = int'(H_in1) * 10 + int'(H_in0);
    mn_in   = int'(M_in1) * 10 + int'(M_in0);
    ok      = (hr_in <= 23) && (H_in0 <= 9) && (M_in1 <= 5) && (M_in0 <= 9);
    cur_min = m_sec / 60;
    hit     = -1;
    if (m_eval)
      for (int i = N - 1; i >= 0; i--)
        if (AL_EN[i] && m_slot[i] == cur_min) hit = i;
    case (m_st)
      0: if (hit >= 0) begin m_st = 1; m_src = hit; m_rcnt = 0; end
      1: begin
        if (STOP_al) m_st = 0;
        else if (SNOOZE) begin m_st = 2; m_tgt = (cur_min + SNZ) % 1440; end
        else if (m_rcnt >= RMAX) m_st = 0;
        else if (tick) m_rcnt++;
      end
      default: begin
        if (STOP_al) m_st = 0;
        else if (m_sec == m_tgt * 60) begin m_st = 1; m_rcnt = 0; end
        else if (hit >= 0) begin m_st = 1; m_src = hit; m_rcnt = 0; end
      end
    endcase
    m_eval = (LD_time && ok) || (tick && (m_sec % 60 == 59));
    if (LD_time && ok) begin m_sec = hr_in * 3600 + mn_in * 60; m_div = 0; end
    else if (tick) begin m_sec = (m_sec + 1) % 86400; m_div = 0; end
    else m_div++;
    if (LD_alarm && ok && alarm_sel < N) m_slot[alarm_sel] = hr_in * 60 + mn_in;
  endtask

  function automatic logic [27:0] expv();
    int hr, d, mn;
    hr = m_sec / 3600;
    mn = (m_sec / 60) % 60;
    d  = mode_12h ? ((hr == 0) ? 12 : ((hr > 12) ? hr - 12 : hr)) : hr;
    return {2'(d / 10), 4'(d % 10), 4'(mn / 10), 4'(mn % 10), 4'((m_sec % 60) / 10),
            4'(m_sec % 10), 1'(hr >= 12), 1'(m_st == 1), 2'(m_src), 1'(m_st == 2),
            1'(m_div == CLK_DIV - 1)};
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("cycle", {4'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, PM, Alarm,
                  alarm_src, snoozed, tick_1s}, {4'b0, expv()});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_hm(input int h, input int m);
    H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
  endtask

  task automatic load_time(input int h, input int m);
    set_hm(h, m); LD_time = 1'b1; cyc(); LD_time = 1'b0;
  endtask

  task automatic load_alarm(input int sel, input int h, input int m);
    set_hm(h, m); alarm_sel = 2'(sel); LD_alarm = 1'b1; cyc(); LD_alarm = 1'b0;
  endtask

  task automatic wait_alarm(input string tag, input logic exp, input int budget);
    int k = 0;
    while (Alarm !== exp && k < budget) begin cyc(); k++; end
    chk(tag, 32'(Alarm), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; LD_time = 0; LD_alarm = 0; alarm_sel = 0; AL_EN = 0;
    STOP_al = 0; SNOOZE = 0; mode_12h = 0; set_hm(0, 0);
    run(2);
    reset = 1'b1;
    chk("rst_time", {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 32'h0);
    chk("rst_flags", {27'b0, PM, Alarm, alarm_src, snoozed}, 32'h0);

    // Rollover
    load_time(23, 59);
    run(240);
    chk("roll_000000", {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 32'h0);
    run(4);
    chk("roll_000001", {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 32'h1);
    chk("roll_pm", 32'(PM), 32'h0);

    // Two slots on the same time, lowest enabled index reported
    load_alarm(1, 7, 30);
    load_alarm(2, 7, 30);
    AL_EN = 4'b0110;
    load_time(7, 29);
    run(240);
    wait_alarm("multi_ring", 1'b1, 4);
    chk("multi_src", 32'(alarm_src), 32'd1);
    STOP_al = 1'b1; cyc(); STOP_al = 1'b0;
    chk("multi_stop", 32'(Alarm), 32'h0);

    // Snooze and return at target
    load_time(7, 29);
    run(240);
    wait_alarm("snz_ring", 1'b1, 4);
    run(3);
    SNOOZE = 1'b1; cyc(); SNOOZE = 1'b0;
    chk("snz_flag", {30'b0, Alarm, snoozed}, 32'h1);
    wait_alarm("snz_back", 1'b1, 1400);
    chk("snz_time", {24'b0, M_out1, M_out0}, 32'h35);
    chk("snz_src", {29'b0, alarm_src, snoozed}, 32'h2);
    STOP_al = 1'b1; cyc(); STOP_al = 1'b0;

    // Unattended ring times out after RMAX seconds
    load_time(7, 30);
    wait_alarm("to_ring", 1'b1, 3);
    run(8);
    chk("to_still", 32'(Alarm), 32'h1);
    wait_alarm("to_stop", 1'b0, 8);

    // Invalid loads leave time untouched
    load_time(10, 0);
    H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 4'd0; M_in0 = 4'd0; LD_time = 1'b1; cyc();
    H_in1 = 2'd1; H_in0 = 4'd2; M_in1 = 4'd6; M_in0 = 4'd0; cyc(); LD_time = 1'b0;
    chk("inv_time", {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 32'h100000);

    // STOP and SNOOZE together
    load_time(7, 30);
    wait_alarm("ss_ring", 1'b1, 3);
    STOP_al = 1'b1; SNOOZE = 1'b1; cyc(); STOP_al = 1'b0; SNOOZE = 1'b0;
    chk("ss_idle", {30'b0, Alarm, snoozed}, 32'h0);

    // 12-hour display
    mode_12h = 1'b1;
    load_time(0, 15);
    chk("h12_0015", {25'b0, H_out1, H_out0, PM}, {25'b0, 2'd1, 4'd2, 1'b0});
    load_time(13, 5);
    chk("h12_1305", {25'b0, H_out1, H_out0, PM}, {25'b0, 2'd0, 4'd1, 1'b1});
    load_time(12, 0);
    chk("h12_1200", {25'b0, H_out1, H_out0, PM}, {25'b0, 2'd1, 4'd2, 1'b1});
    mode_12h = 1'b0;
    load_time(13, 5);
    chk("h24_1305", {25'b0, H_out1, H_out0, PM}, {25'b0, 2'd1, 4'd3, 1'b1});

    // Reset in the middle of a snooze
    load_time(7, 30);
    wait_alarm("rs_ring", 1'b1, 3);
    SNOOZE = 1'b1; cyc(); SNOOZE = 1'b0;
    chk("rs_snz", 32'(snoozed), 32'h1);
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("rs_time", {10'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0}, 32'h0);
    chk("rs_flags", {28'b0, Alarm, alarm_src, snoozed}, 32'h0);
    AL_EN = 4'b0000;
    load_time(0, 0);
    run(3);
    chk("rs_quiet", 32'(Alarm), 32'h0);
    AL_EN = 4'b0100;
    load_time(0, 0);
    wait_alarm("rs_slot2", 1'b1, 3);
    chk("rs_src", 32'(alarm_src), 32'd2);
    STOP_al = 1'b1; cyc(); STOP_al = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 5000; n++) begin
      int r, cm;
      LD_time = 0; LD_alarm = 0; STOP_al = 0; SNOOZE = 0; reset = 1'b1;
      cm = m_sec / 60;
      r = int'($urandom_range(0, 999));
      if (r < 12) begin
        LD_time = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          int s = m_slot[$urandom_range(0, N - 1)];
          set_hm(s / 60, s % 60);
        end else begin
          H_in1 = 2'($urandom_range(0, 3)); H_in0 = 4'($urandom_range(0, 11));
          M_in1 = 4'($urandom_range(0, 6)); M_in0 = 4'($urandom_range(0, 10));
        end
      end
      if (int'($urandom_range(0, 99)) < 3) begin
        int t = (cm + int'($urandom_range(0, 2))) % 1440;
        LD_alarm  = 1'b1;
        alarm_sel = 2'($urandom_range(0, N - 1));
        if (!LD_time) set_hm(t / 60, t % 60);
      end
      if (int'($urandom_range(0, 99)) < 2) STOP_al = 1'b1;
      if (int'($urandom_range(0, 99)) < 3) SNOOZE = 1'b1;
      if (int'($urandom_range(0, 99)) < 1) AL_EN = 4'($urandom_range(0, 15));
      if (int'($urandom_range(0, 99)) < 1) mode_12h = ~mode_12h;
      if (int'($urandom_range(0, 1999)) < 1) reset = 1'b0;
      cyc();
    end
    reset = 1'b1; LD_time = 0; LD_alarm = 0; STOP_al = 0; SNOOZE = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
